// File: rtl/mem_access_unit_if.sv
// Handshaked data-memory port between the memory stage (master) and the data memory (slave).
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   Address;
  logic                    MemRead;
  logic                    MemWrite;
  logic [DATA_WIDTH-1:0]   Write_data;
  logic [DATA_WIDTH/8-1:0] Write_strb;
  logic                    Mem_Req_Ack;
  logic [DATA_WIDTH-1:0]   Read_data;
  logic                    Read_data_Valid;
  logic                    Read_data_Ready;

  modport master (
    output Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready,
    input  Mem_Req_Ack, Read_data, Read_data_Valid
  );

  modport slave (
    input  Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready,
    output Mem_Req_Ack, Read_data, Read_data_Valid
  );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS memory stage: runs one little-endian load/store (incl. lwl/lwr/swl/swr) per start request
// on the handshaked data-memory port and returns the extended or merged load result.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] load_data,
  mem_access_unit_if.master     mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDW, S_DONE} state_e;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_WL = 3'b010;
  localparam logic [2:0] OP_W  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam logic [2:0] OP_WR = 3'b110;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_lane_t;

  function automatic logic op_is_valid(input logic st, input logic [2:0] o);
    if (st) return (o == OP_B) || (o == OP_H) || (o == OP_WL) || (o == OP_W) || (o == OP_WR);
    return o != 3'b111;
  endfunction

  function automatic wr_lane_t store_lanes(input logic [2:0] o, input logic [1:0] a,
                                           input logic [31:0] t);
    wr_lane_t l;
    l = '0;
    case (o)
      OP_B: begin
        l.strb = 4'b0001 << a;
        l.data = {4{t[7:0]}};
      end
      OP_H: begin
        l.strb = a[1] ? 4'b1100 : 4'b0011;
        l.data = {2{t[15:0]}};
      end
      OP_W: l = '{strb: 4'b1111, data: t};
      OP_WL: begin
        case (a)
          2'd0:    l = '{strb: 4'b0001, data: {24'b0, t[31:24]}};
          2'd1:    l = '{strb: 4'b0011, data: {16'b0, t[31:16]}};
          2'd2:    l = '{strb: 4'b0111, data: {8'b0, t[31:8]}};
          default: l = '{strb: 4'b1111, data: t};
        endcase
      end
      OP_WR: begin
        case (a)
          2'd0:    l = '{strb: 4'b1111, data: t};
          2'd1:    l = '{strb: 4'b1110, data: {t[23:0], 8'b0}};
          2'd2:    l = '{strb: 4'b1100, data: {t[15:0], 16'b0}};
          default: l = '{strb: 4'b1000, data: {t[7:0], 24'b0}};
        endcase
      end
      default: l = '0;
    endcase
    return l;
  endfunction

  // lwl keeps the low rt bytes below the loaded ones, lwr keeps the high rt bytes above them.
  function automatic logic [31:0] load_merge(input logic [2:0] o, input logic [1:0] a,
                                             input logic [31:0] r, input logic [31:0] t);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = r[8*a +: 8];
    h = a[1] ? r[31:16] : r[15:0];
    v = '0;
    case (o)
      OP_B:  v = {{24{b[7]}}, b};
      OP_BU: v = {24'b0, b};
      OP_H:  v = {{16{h[15]}}, h};
      OP_HU: v = {16'b0, h};
      OP_W:  v = r;
      OP_WL: begin
        case (a)
          2'd0:    v = {r[7:0], t[23:0]};
          2'd1:    v = {r[15:0], t[15:0]};
          2'd2:    v = {r[23:0], t[7:0]};
          default: v = r;
        endcase
      end
      OP_WR: begin
        case (a)
          2'd0:    v = r;
          2'd1:    v = {t[31:24], r[31:8]};
          2'd2:    v = {t[31:16], r[31:16]};
          default: v = {t[31:8], r[31:24]};
        endcase
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  state_e                  state_q, state_d;
  logic                    is_store_q, is_store_d;
  logic [2:0]              op_q, op_d;
  logic [1:0]              a_q, a_d;
  logic [DATA_WIDTH-1:0]   rt_q, rt_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
  wr_lane_t                lanes;
  logic                    start_valid;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    is_store_d  = is_store_q;
    op_d        = op_q;
    a_d         = a_q;
    rt_d        = rt_q;
    address_d   = address_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    load_data_d = load_data_q;
    start_valid = op_is_valid(is_store, op);
    lanes       = (is_store && start_valid) ? store_lanes(op, addr[1:0], rt_data) : '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          op_d       = op;
          a_d        = addr[1:0];
          rt_d       = rt_data;
          address_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
          wstrb_d    = lanes.strb;
          wdata_d    = lanes.data;
          if (start_valid) begin
            state_d = S_REQ;
          end else begin
            state_d     = S_DONE;
            load_data_d = '0;
          end
        end
      end
      S_REQ: begin
        if (mem.Mem_Req_Ack) state_d = is_store_q ? S_DONE : S_RDW;
      end
      S_RDW: begin
        if (mem.Read_data_Valid) begin
          load_data_d = load_merge(op_q, a_q, mem.Read_data, rt_q);
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      rt_q        <= '0;
      address_q   <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      op_q        <= op_d;
      a_q         <= a_d;
      rt_q        <= rt_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      load_data_q <= load_data_d;
    end
  end

  assign busy                = (state_q != S_IDLE);
  assign done                = (state_q == S_DONE);
  assign load_data           = load_data_q;
  assign mem.Address         = address_q;
  assign mem.Write_data      = wdata_q;
  assign mem.Write_strb      = wstrb_q;
  assign mem.MemRead         = (state_q == S_REQ) && !is_store_q;
  assign mem.MemWrite        = (state_q == S_REQ) && is_store_q;
  assign mem.Read_data_Ready = (state_q == S_RDW);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vectors plus randomized loads/stores with
// random handshake delays, checked against a byte-lane reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_store  (is_store),
    .op        (op),
    .addr      (addr),
    .rt_data   (rt_data),
    .busy      (busy),
    .done      (done),
    .load_data (load_data),
    .mem       (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  logic [31:0] model_ld = '0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_valid(input logic st, input logic [2:0] o);
    if (st) return o inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    return o != 3'd7;
  endfunction

  // Loads described as byte-lane arithmetic on the read word.
  function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [1:0] a,
                                           input logic [31:0] r, input logic [31:0] t);
    int          ai;
    logic [31:0] v;
    ai = int'(a);
    v  = '0;
    case (o)
      3'd0: begin v = (r >> (8*ai)) & 32'hFF; if (v[7]) v = v | 32'hFFFFFF00; end
      3'd4: v = (r >> (8*ai)) & 32'hFF;
      3'd1: begin v = (r >> (16*(ai/2))) & 32'hFFFF; if (v[15]) v = v | 32'hFFFF0000; end
      3'd5: v = (r >> (16*(ai/2))) & 32'hFFFF;
      3'd3: v = r;
      3'd2: v = (r << (8*(3-ai))) | (t & (32'hFFFFFFFF >> (8*(ai+1))));
      3'd6: v = (r >> (8*ai)) | (t & ~(32'hFFFFFFFF >> (8*ai)));
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] o, input logic [1:0] a, input logic [31:0] t,
                           output logic [3:0] strb, output logic [31:0] data);
    int         ai;
    logic [3:0] all_ones;
    ai       = int'(a);
    all_ones = 4'b1111;
    strb     = '0;
    data     = '0;
    case (o)
      3'd0: begin strb = 4'b0001 << ai; data = {4{t[7:0]}}; end
      3'd1: begin strb = (ai >= 2) ? 4'b1100 : 4'b0011; data = {2{t[15:0]}}; end
      3'd3: begin strb = 4'b1111; data = t; end
      3'd2: begin strb = all_ones >> (3-ai); data = t >> (8*(3-ai)); end
      3'd6: begin strb = all_ones << ai; data = t << (8*ai); end
      default: ;
    endcase
  endtask

  task automatic run_txn(input logic st, input logic [2:0] o, input logic [31:0] ad,
                         input logic [31:0] t, input logic [31:0] rd,
                         input int ack_d, input int val_d, input bit poke);
    bit          ok, got_done, saw_req, req_now, rdy_now;
    int          edges, req_cyc, rd_cyc, exp_lat;
    logic [31:0] exp_addr, exp_data;
    logic [3:0]  exp_strb;
    ok       = ref_valid(st, o);
    exp_addr = {ad[31:2], 2'b00};
    exp_strb = '0;
    exp_data = '0;
    if (st && ok) ref_store(o, ad[1:0], t, exp_strb, exp_data);
    exp_lat  = !ok ? 1 : (st ? ack_d + 2 : ack_d + val_d + 3);

    start = 1'b1; is_store = st; op = o; addr = ad; rt_data = t;
    edges = 0; req_cyc = 0; rd_cyc = 0; got_done = 0; saw_req = 0;
    while (!got_done && edges < 64) begin
      req_now = bus.MemRead | bus.MemWrite;
      rdy_now = bus.Read_data_Ready;
      if (edges > 0) begin
        start = poke && req_now;
        if (start) begin
          is_store = 1'($urandom); op = 3'($urandom); addr = $urandom; rt_data = $urandom;
        end
      end
      bus.Mem_Req_Ack     = req_now && (req_cyc >= ack_d);
      bus.Read_data_Valid = rdy_now && (rd_cyc >= val_d);
      bus.Read_data       = bus.Read_data_Valid ? rd : $urandom;
      if (req_now) begin
        saw_req = 1;
        check("req_addr", bus.Address, exp_addr);
        check("req_strb", 32'(bus.Write_strb), 32'(exp_strb));
        check("req_wdata", bus.Write_data, exp_data);
        check("req_kind", {bus.MemWrite, bus.MemRead}, st ? 32'd2 : 32'd1);
      end
      step;
      edges++;
      if (req_now) req_cyc++;
      if (rdy_now) rd_cyc++;
      if (done) got_done = 1;
    end
    start = 1'b0;
    bus.Mem_Req_Ack = 1'b0;
    bus.Read_data_Valid = 1'b0;

    if (!ok) model_ld = '0;
    else if (!st) model_ld = ref_load(o, ad[1:0], rd, t);
    exp_done++;
    check("done_seen", 32'(got_done), 32'd1);
    check("latency", edges, exp_lat);
    check("req_seen", 32'(saw_req), 32'(ok));
    check("req_cycles", req_cyc, ok ? ack_d + 1 : 0);
    check("busy_at_done", 32'(busy), 32'd1);
    check("load_data", load_data, model_ld);
    step;
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("load_hold", load_data, model_ld);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; op = '0; addr = '0; rt_data = '0;
    bus.Mem_Req_Ack = 1'b0; bus.Read_data_Valid = 1'b0; bus.Read_data = '0;
    step; step;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", {bus.MemWrite, bus.MemRead, bus.Read_data_Ready}, 32'd0);
    check("rst_addr", bus.Address, 32'd0);
    check("rst_wdata", bus.Write_data, 32'd0);
    check("rst_strb", 32'(bus.Write_strb), 32'd0);
    check("rst_load", load_data, 32'd0);
    rst = 1'b0;
    step;

    run_txn(0, 3'd0, 32'h1002, 32'h0, 32'h80FF7F00, 0, 0, 0);
    check("lb_vec", load_data, 32'hFFFFFFFF);
    run_txn(0, 3'd4, 32'h1002, 32'h0, 32'h80FF7F00, 0, 0, 0);
    check("lbu_vec", load_data, 32'h000000FF);
    run_txn(0, 3'd5, 32'h1002, 32'h0, 32'h80FF7F00, 0, 0, 0);
    check("lhu_vec", load_data, 32'h000080FF);
    run_txn(0, 3'd2, 32'h1001, 32'h11223344, 32'hAABBCCDD, 0, 0, 0);
    check("lwl_vec", load_data, 32'hCCDD3344);
    run_txn(0, 3'd6, 32'h1001, 32'h11223344, 32'hAABBCCDD, 0, 0, 0);
    check("lwr_vec", load_data, 32'h11AABBCC);
    run_txn(1, 3'd6, 32'h2001, 32'h11223344, 32'h0, 0, 0, 0);
    run_txn(1, 3'd2, 32'h2001, 32'h11223344, 32'h0, 0, 0, 0);
    run_txn(1, 3'd3, 32'h3000, 32'hDEADBEEF, 32'h0, 5, 0, 1);
    run_txn(0, 3'd3, 32'h3004, 32'h0, 32'h12345678, 2, 4, 1);
    run_txn(0, 3'd7, 32'h4000, 32'h0, 32'h0, 0, 0, 0);
    run_txn(1, 3'd5, 32'h4000, 32'h55, 32'h0, 0, 0, 0);

    // Reset while waiting for read data: transaction dropped without a done pulse.
    start = 1'b1; is_store = 1'b0; op = 3'd3; addr = 32'h40; rt_data = '0;
    step;
    start = 1'b0;
    bus.Mem_Req_Ack = 1'b1;
    step;
    bus.Mem_Req_Ack = 1'b0;
    check("rdw_ready", 32'(bus.Read_data_Ready), 32'd1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    model_ld = '0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(bus.Read_data_Ready), 32'd0);
    check("abort_load", load_data, model_ld);
    step; step;

    for (int i = 0; i < 150; i++) begin
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    check("done_count", done_cnt, exp_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
